// File: rtl/ftm_nmr_voter.sv
// N-modular-redundancy write-port voter and recovery sequencer for lockstep cores.
// Optional per-core error statistics: define FTM_NMR_ERR_STATS_EN.
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_RUN       | normal operation, write ports compared and voted
// ST_RECOVER   | one-cycle debug request to the cores
// ST_WAIT_DONE | waiting for the recovery routine, bounded by TIMEOUT
// ST_RESET     | core reset held for RESET_CYCLES
// ST_FAIL      | unrecoverable, left only through rst_i
module ftm_nmr_voter #(
    parameter int NUM_CORES    = 3,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int MAX_RETRIES  = 3,
    parameter int CLEAN_INSTRS = 64,
    parameter int RESET_CYCLES = 4,
    parameter int TIMEOUT      = 1024
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             enable_i,
    input  logic [NUM_CORES-1:0]             we_i,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0]  waddr_i,
    input  logic [NUM_CORES*DATA_WIDTH-1:0]  wdata_i,
    input  logic [DATA_WIDTH-1:0]            pc_i,
    input  logic                             valid_instr_i,
    input  logic                             done_i,
    output logic                             voted_we_o,
    output logic [ADDR_WIDTH-1:0]            voted_waddr_o,
    output logic [DATA_WIDTH-1:0]            voted_wdata_o,
    output logic                             mismatch_o,
    output logic [NUM_CORES-1:0]             faulty_mask_o,
    output logic [DATA_WIDTH-1:0]            checkpoint_pc_o,
    output logic                             recover_o,
    output logic                             recovering_o,
    output logic                             reset_o,
    output logic                             fail_o,
    output logic [NUM_CORES*8-1:0]           err_cnt_o
);

    localparam int TW  = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int RW  = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
    localparam int CW  = $clog2(CLEAN_INSTRS + 1);
    localparam int TOW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int RCW = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_RECOVER,
        ST_WAIT_DONE,
        ST_RESET,
        ST_FAIL
    } state_t;

    state_t state_q, state_d;

    logic [TW-1:0]        tuple [NUM_CORES];
    logic [3:0]           agree [NUM_CORES];
    logic [TW-1:0]        maj_t;
    logic [TW-1:0]        voted_t;
    logic                 maj_found;
    logic                 all_equal;
    logic                 compare_active;
    logic                 mismatch_d;
    logic                 clean_hit;
    logic [NUM_CORES-1:0] new_mask;

    logic [RW-1:0]        retry_q;
    logic [CW-1:0]        clean_q;
    logic [TOW-1:0]       tmo_q;
    logic [RCW-1:0]       rcnt_q;

    // Address and data only take part in the comparison when the core writes.
    always_comb begin
        for (int k = 0; k < NUM_CORES; k++) begin
            tuple[k] = '0;
            if (we_i[k]) begin
                tuple[k] = {1'b1, waddr_i[k*ADDR_WIDTH +: ADDR_WIDTH],
                            wdata_i[k*DATA_WIDTH +: DATA_WIDTH]};
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_CORES; k++) begin
            agree[k] = '0;
            for (int j = 0; j < NUM_CORES; j++) begin
                if (tuple[j] == tuple[k]) agree[k] = agree[k] + 4'd1;
            end
        end
    end

    always_comb begin
        all_equal = 1'b1;
        maj_found = 1'b0;
        maj_t     = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (tuple[k] != tuple[0]) all_equal = 1'b0;
            if (!maj_found && (agree[k] > 4'(NUM_CORES / 2))) begin
                maj_found = 1'b1;
                maj_t     = tuple[k];
            end
        end
    end

    assign compare_active = (state_q == ST_RUN) && enable_i;
    assign mismatch_d     = compare_active && !all_equal;
    assign clean_hit      = (state_q == ST_RUN) && valid_instr_i && !mismatch_d;

    always_comb begin
        voted_t  = {we_i[0], waddr_i[ADDR_WIDTH-1:0], wdata_i[DATA_WIDTH-1:0]};
        new_mask = '0;
        if (compare_active) begin
            if (maj_found) begin
                voted_t = maj_t;
                for (int j = 0; j < NUM_CORES; j++) begin
                    new_mask[j] = (tuple[j] != maj_t);
                end
            end else begin
                voted_t         = tuple[0];
                voted_t[TW-1]   = 1'b0;
                new_mask        = '1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        recover_o    = 1'b0;
        recovering_o = 1'b0;
        reset_o      = 1'b0;
        fail_o       = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mismatch_d) begin
                    state_d = (retry_q == RW'(MAX_RETRIES)) ? ST_FAIL : ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                recover_o    = 1'b1;
                recovering_o = 1'b1;
                state_d      = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                recovering_o = 1'b1;
                if (done_i)             state_d = ST_RESET;
                else if (tmo_q == '0)   state_d = ST_FAIL;
            end
            ST_RESET: begin
                reset_o      = 1'b1;
                recovering_o = 1'b1;
                if (rcnt_q == '0) state_d = ST_RUN;
            end
            ST_FAIL: begin
                fail_o = 1'b1;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= ST_RUN;
            voted_we_o      <= 1'b0;
            voted_waddr_o   <= '0;
            voted_wdata_o   <= '0;
            mismatch_o      <= 1'b0;
            faulty_mask_o   <= '0;
            checkpoint_pc_o <= '0;
            retry_q         <= '0;
            clean_q         <= '0;
            tmo_q           <= TOW'(TIMEOUT - 1);
            rcnt_q          <= RCW'(RESET_CYCLES - 1);
        end else begin
            state_q       <= state_d;
            voted_we_o    <= voted_t[TW-1];
            voted_waddr_o <= voted_t[DATA_WIDTH +: ADDR_WIDTH];
            voted_wdata_o <= voted_t[DATA_WIDTH-1:0];
            mismatch_o    <= mismatch_d;

            if (state_q == ST_RESET && state_d == ST_RUN) faulty_mask_o <= '0;
            else if (mismatch_d)                          faulty_mask_o <= faulty_mask_o | new_mask;

            if (clean_hit) checkpoint_pc_o <= pc_i;

            // A mismatch always wins over a clean-window completion.
            if (mismatch_d) begin
                clean_q <= '0;
                if (state_d == ST_RECOVER) retry_q <= retry_q + 1'b1;
            end else if (clean_hit) begin
                if (clean_q == CW'(CLEAN_INSTRS - 1)) begin
                    clean_q <= '0;
                    retry_q <= '0;
                end else begin
                    clean_q <= clean_q + 1'b1;
                end
            end

            tmo_q  <= (state_q == ST_WAIT_DONE) ? tmo_q - 1'b1  : TOW'(TIMEOUT - 1);
            rcnt_q <= (state_q == ST_RESET)     ? rcnt_q - 1'b1 : RCW'(RESET_CYCLES - 1);
        end
    end

`ifdef FTM_NMR_ERR_STATS_EN
    logic [7:0] err_q [NUM_CORES];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_CORES; k++) err_q[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_CORES; k++) begin
                if (mismatch_d && new_mask[k] && !faulty_mask_o[k] && err_q[k] != 8'hFF) begin
                    err_q[k] <= err_q[k] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        err_cnt_o = '0;
        for (int k = 0; k < NUM_CORES; k++) err_cnt_o[k*8 +: 8] = err_q[k];
    end
`else
    assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ftm_nmr_voter.sv
// Randomised and directed bench for ftm_nmr_voter against a behavioural model.
module tb_ftm_nmr_voter;
    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = 5;

    logic              clk_i = 1'b0;
    logic              rst_i, enable_i, valid_instr_i, done_i;
    logic [N-1:0]      we_i;
    logic [N*AW-1:0]   waddr_i;
    logic [N*DW-1:0]   wdata_i;
    logic [DW-1:0]     pc_i;
    logic              voted_we_o, mismatch_o, recover_o, recovering_o, reset_o, fail_o;
    logic [AW-1:0]     voted_waddr_o;
    logic [DW-1:0]     voted_wdata_o, checkpoint_pc_o;
    logic [N-1:0]      faulty_mask_o;
    logic [N*8-1:0]    err_cnt_o;

    ftm_nmr_voter dut (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .we_i(we_i),
        .waddr_i(waddr_i), .wdata_i(wdata_i), .pc_i(pc_i),
        .valid_instr_i(valid_instr_i), .done_i(done_i),
        .voted_we_o(voted_we_o), .voted_waddr_o(voted_waddr_o),
        .voted_wdata_o(voted_wdata_o), .mismatch_o(mismatch_o),
        .faulty_mask_o(faulty_mask_o), .checkpoint_pc_o(checkpoint_pc_o),
        .recover_o(recover_o), .recovering_o(recovering_o), .reset_o(reset_o),
        .fail_o(fail_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: phase 0 run, 1 recover, 2 wait-done, 3 core reset, 4 fail.
    int            m_phase, m_wait_elapsed, m_reset_elapsed, m_retry, m_clean;
    logic          m_we, m_mm;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data, m_cp;
    logic [N-1:0]  m_mask;
    int            m_err [N];

    function automatic bit same(input int j, input int k);
        if (we_i[j] != we_i[k]) return 0;
        if (!we_i[j]) return 1;
        return (waddr_i[j*AW +: AW] == waddr_i[k*AW +: AW]) &&
               (wdata_i[j*DW +: DW] == wdata_i[k*DW +: DW]);
    endfunction

    task automatic model_step();
        bit act, alleq, mm, clean;
        int maj, cnt;
        logic [N-1:0] nm;
        if (rst_i) begin
            m_phase = 0; m_wait_elapsed = 0; m_reset_elapsed = 0; m_retry = 0; m_clean = 0;
            m_we = 0; m_mm = 0; m_addr = '0; m_data = '0; m_cp = '0; m_mask = '0;
            for (int k = 0; k < N; k++) m_err[k] = 0;
            return;
        end
        act = (m_phase == 0) && enable_i;
        alleq = 1; maj = -1; nm = '0;
        for (int k = 0; k < N; k++) begin
            cnt = 0;
            for (int j = 0; j < N; j++) if (same(j, k)) cnt++;
            if (maj < 0 && cnt > N / 2) maj = k;
            if (!same(k, 0)) alleq = 0;
        end
        mm = act && !alleq;
        if (act && maj >= 0) begin
            m_we   = we_i[maj];
            m_addr = we_i[maj] ? waddr_i[maj*AW +: AW] : '0;
            m_data = we_i[maj] ? wdata_i[maj*DW +: DW] : '0;
            for (int j = 0; j < N; j++) nm[j] = !same(j, maj);
        end else if (act) begin
            m_we   = 0;
            m_addr = we_i[0] ? waddr_i[AW-1:0] : '0;
            m_data = we_i[0] ? wdata_i[DW-1:0] : '0;
            nm     = '1;
        end else begin
            m_we = we_i[0]; m_addr = waddr_i[AW-1:0]; m_data = wdata_i[DW-1:0];
        end
`ifdef FTM_NMR_ERR_STATS_EN
        for (int k = 0; k < N; k++)
            if (mm && nm[k] && !m_mask[k] && m_err[k] < 255) m_err[k]++;
`endif
        clean = (m_phase == 0) && valid_instr_i && !mm;
        if (clean) m_cp = pc_i;
        case (m_phase)
            0: begin
                if (mm) begin
                    m_mask  = m_mask | nm;
                    m_clean = 0;
                    if (m_retry == 3) m_phase = 4;
                    else begin m_retry++; m_phase = 1; end
                end else if (clean) begin
                    m_clean++;
                    if (m_clean == 64) begin m_clean = 0; m_retry = 0; end
                end
            end
            1: begin m_phase = 2; m_wait_elapsed = 0; end
            2: begin
                if (done_i) begin m_phase = 3; m_reset_elapsed = 0; end
                else if (m_wait_elapsed == 1023) m_phase = 4;
                else m_wait_elapsed++;
            end
            3: begin
                m_reset_elapsed++;
                if (m_reset_elapsed == 4) begin m_phase = 0; m_mask = '0; end
            end
            default: ;
        endcase
        m_mm = mm;
    endtask

    task automatic step(input string tag);
        logic [N*8-1:0] e;
        model_step();
        @(posedge clk_i); #1;
        for (int k = 0; k < N; k++) e[k*8 +: 8] = 8'(m_err[k]);
        check({tag, ".we"},   64'(voted_we_o),      64'(m_we));
        check({tag, ".addr"}, 64'(voted_waddr_o),   64'(m_addr));
        check({tag, ".data"}, 64'(voted_wdata_o),   64'(m_data));
        check({tag, ".mm"},   64'(mismatch_o),      64'(m_mm));
        check({tag, ".mask"}, 64'(faulty_mask_o),   64'(m_mask));
        check({tag, ".cp"},   64'(checkpoint_pc_o), 64'(m_cp));
        check({tag, ".rcv"},  64'(recover_o),       64'(m_phase == 1));
        check({tag, ".rcvg"}, 64'(recovering_o),    64'(m_phase >= 1 && m_phase <= 3));
        check({tag, ".rst"},  64'(reset_o),         64'(m_phase == 3));
        check({tag, ".fail"}, 64'(fail_o),          64'(m_phase == 4));
        check({tag, ".err"},  64'(err_cnt_o),       64'(e));
    endtask

    task automatic drive_all(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        for (int k = 0; k < N; k++) begin
            we_i[k] = w; waddr_i[k*AW +: AW] = a; wdata_i[k*DW +: DW] = d;
        end
    endtask

    task automatic idle();
        drive_all(1'b0, '0, '0);
        valid_instr_i = 0; done_i = 0; rst_i = 0; enable_i = 1;
    endtask

    task automatic do_fault(input int core);
        drive_all(1'b1, 5'd7, 32'hCAFE0000);
        wdata_i[core*DW +: DW] = 32'h0000FFFF;
        step("fault");
        idle();
    endtask

    task automatic finish_recovery(input int wait_cycles);
        int n;
        n = 0;
        idle();
        repeat (wait_cycles) step("wait");
        done_i = 1; step("done"); done_i = 0;
        while (recovering_o && n < 20) begin step("rstc"); n++; end
        check("rec_exit", 64'(recovering_o), 64'd0);
    endtask

    task automatic clean_instrs(input int n);
        for (int i = 0; i < n; i++) begin
            drive_all(1'b1, 5'(i), 32'(i * 3));
            valid_instr_i = 1; pc_i = 32'h1000 + 32'(i * 4);
            step("clean");
        end
        idle();
    endtask

    task automatic rand_inputs();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic w;
        a = AW'($urandom); d = $urandom; w = ($urandom_range(0, 7) != 0);
        drive_all(w, a, d);
        for (int k = 0; k < N; k++) begin
            case ($urandom_range(0, 11))
                0: wdata_i[k*DW +: DW] = wdata_i[k*DW +: DW] ^ (32'd1 << $urandom_range(0, 31));
                1: we_i[k] = ~w;
                2: waddr_i[k*AW +: AW] = waddr_i[k*AW +: AW] ^ 5'd1;
                default: ;
            endcase
        end
        enable_i      = ($urandom_range(0, 9) != 0);
        valid_instr_i = 1'($urandom_range(0, 1));
        pc_i          = $urandom;
        done_i        = ($urandom_range(0, 7) == 0);
        rst_i         = ($urandom_range(0, 199) == 0);
    endtask

    initial begin
        int n, rc;
        idle(); pc_i = '0; rst_i = 1;
        step("reset"); step("reset");
        check("reset_cp", 64'(checkpoint_pc_o), 64'd0);
        check("reset_fail", 64'(fail_o), 64'd0);
        idle();

        drive_all(1'b1, 5'd5, 32'hDEADBEEF);
        step("agree");
        check("agree_we", 64'(voted_we_o), 64'd1);
        check("agree_addr", 64'(voted_waddr_o), 64'd5);
        check("agree_data", 64'(voted_wdata_o), 64'hDEADBEEF);
        check("agree_mm", 64'(mismatch_o), 64'd0);

        wdata_i[1*DW +: DW] = 32'h1234;
        step("single");
        check("single_data", 64'(voted_wdata_o), 64'hDEADBEEF);
        check("single_mm", 64'(mismatch_o), 64'd1);
        check("single_mask", 64'(faulty_mask_o), 64'b010);
        check("single_rcv", 64'(recover_o), 64'd1);
        idle();
        step("wait1");
        check("single_rcv_pulse", 64'(recover_o), 64'd0);
        check("single_rcvg", 64'(recovering_o), 64'd1);
        repeat (8) step("wait");
        done_i = 1; step("done"); done_i = 0;
        rc = reset_o ? 1 : 0; n = 0;
        while (recovering_o && n < 20) begin step("rstc"); n++; if (reset_o) rc++; end
        check("reset_len", 64'(rc), 64'd4);
        check("mask_clr", 64'(faulty_mask_o), 64'd0);

        for (int k = 0; k < N; k++) begin
            we_i[k] = 1; waddr_i[k*AW +: AW] = 5'd3; wdata_i[k*DW +: DW] = 32'(k + 100);
        end
        step("nomaj");
        check("nomaj_we", 64'(voted_we_o), 64'd0);
        check("nomaj_mask", 64'(faulty_mask_o), 64'b111);
        check("nomaj_rcv", 64'(recover_o), 64'd1);
        finish_recovery(3);

        do_fault(0);
        step("enter_wait");
        n = 0;
        while (!fail_o && n < 1100) begin step("tmo"); n++; end
        check("timeout_len", 64'(n), 64'd1024);
        done_i = 1; repeat (5) step("failhold"); done_i = 0;
        check("fail_sticky", 64'(fail_o), 64'd1);

        rst_i = 1; step("reset"); idle();
        for (int i = 0; i < 3; i++) begin do_fault(2); finish_recovery(2); clean_instrs(5); end
        do_fault(2);
        check("retry_fail", 64'(fail_o), 64'd1);

        rst_i = 1; step("reset"); idle();
        for (int i = 0; i < 3; i++) begin do_fault(2); finish_recovery(2); end
        clean_instrs(64);
        do_fault(2);
        check("clean_rcv", 64'(recover_o), 64'd1);
        check("clean_nofail", 64'(fail_o), 64'd0);
        finish_recovery(1);

        rst_i = 1; step("reset"); idle();
        for (int i = 0; i < 300; i++) begin
            do_fault(2);
            finish_recovery(1);
            if (i % 3 == 2) clean_instrs(64);
        end
`ifdef FTM_NMR_ERR_STATS_EN
        check("err_sat", 64'(err_cnt_o[2*8 +: 8]), 64'd255);
`else
        check("err_tied", 64'(err_cnt_o), 64'd0);
`endif

        rst_i = 1; step("reset"); idle();
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
